// File: rtl/port_io_pkg.sv
// rtl/port_io_pkg.sv - shared port numbers and decode types for the port_io peripheral
package port_io_pkg;

    localparam int PORT_DISPLAY = 0;
    localparam int PORT_LED     = 1;
    localparam int PORT_SWITCH  = 2;
    localparam int PORT_BUTTON  = 3;
    localparam int PORT_TIMER   = 4;
    localparam int PORT_STATUS  = 5;

    localparam int NUM_BUTTONS  = 4;

    typedef enum logic [2:0] {
        SEL_DISPLAY,
        SEL_LED,
        SEL_SWITCH,
        SEL_BUTTON,
        SEL_TIMER,
        SEL_STATUS,
        SEL_NONE
    } port_sel_e;

    // A set in the same cycle as a read-clear wins, so no event is ever dropped.
    function automatic logic [NUM_BUTTONS-1:0] update_flags(
        input logic [NUM_BUTTONS-1:0] flags,
        input logic                   clear,
        input logic [NUM_BUTTONS-1:0] set
    );
        return (flags & ~{NUM_BUTTONS{clear}}) | set;
    endfunction

endpackage

// File: rtl/port_io_debouncer.sv
// rtl/port_io_debouncer.sv - per-button synchroniser and debouncer with rising-edge pulse
module port_io_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic mclk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          acc_q;
    logic [CW-1:0] cnt_q;
    logic          settle;

    // rise is combinational so the caller's flag lands on the same edge as the accepted level.
    assign settle = (sync2_q != acc_q) && (cnt_q == LAST);
    assign rise   = settle && sync2_q;
    assign level  = acc_q;

    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q == acc_q) begin
                cnt_q <= '0;
            end else if (settle) begin
                acc_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_io.sv
// rtl/port_io.sv - memory-mapped display/LED/switch/button/timer registers on the CPU port bus
module port_io
    import port_io_pkg::*;
#(
    parameter int WORD_SIZE       = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRESCALE        = 50000
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    input  logic [7:0]           sw,
    input  logic [3:0]           btn,
    output logic [15:0]          show_val,
    output logic [7:0]           led_val
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    port_sel_e              sel;
    logic [WORD_SIZE-1:0]   rd_data;

    logic [15:0]            display_q;
    logic [7:0]             led_q;
    logic [7:0]             sw_s1_q;
    logic [7:0]             sw_s2_q;
    logic [7:0]             sw_q;

    logic [NUM_BUTTONS-1:0] btn_rise;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_flags_q;
    logic                   unused_btn_level;

    logic [PW-1:0]          pre_q;
    logic [15:0]            count_q;
    logic [15:0]            period_q;
    logic                   expired_q;
    logic                   tick;
    logic                   expire_evt;

    logic                   wr_display;
    logic                   wr_led;
    logic                   wr_timer;
    logic                   rd_button;
    logic                   rd_status;

    // Full-width compare: aliases such as 0x100 must not hit port 0.
    always_comb begin
        sel = SEL_NONE;
        if (portaddr == WORD_SIZE'(PORT_DISPLAY))     sel = SEL_DISPLAY;
        else if (portaddr == WORD_SIZE'(PORT_LED))    sel = SEL_LED;
        else if (portaddr == WORD_SIZE'(PORT_SWITCH)) sel = SEL_SWITCH;
        else if (portaddr == WORD_SIZE'(PORT_BUTTON)) sel = SEL_BUTTON;
        else if (portaddr == WORD_SIZE'(PORT_TIMER))  sel = SEL_TIMER;
        else if (portaddr == WORD_SIZE'(PORT_STATUS)) sel = SEL_STATUS;
    end

    assign wr_display = portset && (sel == SEL_DISPLAY);
    assign wr_led     = portset && (sel == SEL_LED);
    assign wr_timer   = portset && (sel == SEL_TIMER);
    assign rd_button  = portget && (sel == SEL_BUTTON);
    assign rd_status  = portget && (sel == SEL_STATUS);

    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_DISPLAY: rd_data = WORD_SIZE'(display_q);
            SEL_LED:     rd_data = WORD_SIZE'(led_q);
            SEL_SWITCH:  rd_data = WORD_SIZE'(sw_q);
            SEL_BUTTON:  rd_data = WORD_SIZE'(btn_flags_q);
            SEL_TIMER:   rd_data = WORD_SIZE'(count_q);
            SEL_STATUS:  rd_data = WORD_SIZE'(expired_q);
            default:     rd_data = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            port_io_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .mclk (mclk),
                .rst  (rst),
                .din  (btn[gi]),
                .level(btn_level[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    assign unused_btn_level = ^btn_level;

    always_ff @(posedge mclk) begin
        if (rst) begin
            display_q   <= '0;
            led_q       <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_q        <= '0;
            btn_flags_q <= '0;
            portout     <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            sw_q    <= sw_s2_q;
            if (wr_display) display_q <= 16'(portval);
            if (wr_led)     led_q     <= 8'(portval);
            if (portget)    portout   <= rd_data;
            btn_flags_q <= update_flags(btn_flags_q, rd_button, btn_rise);
        end
    end

    assign tick       = (pre_q == PW'(PRESCALE - 1));
    assign expire_evt = tick && (period_q != 16'd0) && (count_q == period_q);

    // A period write restarts the count; the prescaler keeps its phase.
    always_ff @(posedge mclk) begin
        if (rst) begin
            pre_q     <= '0;
            count_q   <= '0;
            period_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (wr_timer) begin
                period_q <= 16'(portval);
                count_q  <= '0;
            end else if (tick) begin
                count_q <= expire_evt ? 16'd0 : count_q + 16'd1;
            end
            expired_q <= (expired_q && !rd_status) || expire_evt;
        end
    end

    assign show_val = display_q;
    assign led_val  = led_q;

endmodule

// File: tb/tb_port_io.sv
// tb/tb_port_io.sv - directed self-checking bench for port_io
module tb_port_io;

    logic        mclk;
    logic        rst;
    logic [15:0] portaddr;
    logic [15:0] portval;
    logic        portget;
    logic        portset;
    logic [15:0] portout;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic [15:0] show_val;
    logic [7:0]  led_val;

    logic [15:0] wrap_portout;
    logic [15:0] unused_wrap_show;
    logic [7:0]  unused_wrap_led;

    int checks = 0;
    int errors = 0;

    port_io #(.WORD_SIZE(16), .DEBOUNCE_CYCLES(4), .PRESCALE(3)) dut (
        .mclk(mclk), .rst(rst), .portaddr(portaddr), .portval(portval),
        .portget(portget), .portset(portset), .portout(portout),
        .sw(sw), .btn(btn), .show_val(show_val), .led_val(led_val)
    );

    // Fast-ticking instance so the 16-bit count can wrap within the cycle budget.
    port_io #(.WORD_SIZE(16), .DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut_wrap (
        .mclk(mclk), .rst(rst), .portaddr(portaddr), .portval(portval),
        .portget(portget), .portset(portset), .portout(wrap_portout),
        .sw(sw), .btn(btn), .show_val(unused_wrap_show), .led_val(unused_wrap_led)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_out;
        logic [15:0] exp_show;
        logic [7:0]  exp_led;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] v);
        portaddr = a;
        portval  = v;
        portset  = 1'b1;
        @(negedge mclk);
        portset  = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d);
        portaddr = a;
        portget  = 1'b1;
        @(negedge mclk);
        portget  = 1'b0;
        d = portout;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
    endtask

    logic [15:0] rd;

    initial begin
        vecs[0]  = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 8'h00};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 8'h00};
        vecs[2]  = '{1'b1, 16'h0001, 16'hABCD, 16'h1234, 16'h1234, 8'hCD};
        vecs[3]  = '{1'b0, 16'h0001, 16'h0000, 16'h00CD, 16'h1234, 8'hCD};
        vecs[4]  = '{1'b0, 16'h0009, 16'h0000, 16'h0000, 16'h1234, 8'hCD};
        vecs[5]  = '{1'b0, 16'h0002, 16'h0000, 16'h00A5, 16'h1234, 8'hCD};
        vecs[6]  = '{1'b1, 16'h0002, 16'hFFFF, 16'h00A5, 16'h1234, 8'hCD};
        vecs[7]  = '{1'b0, 16'h0002, 16'h0000, 16'h00A5, 16'h1234, 8'hCD};
        vecs[8]  = '{1'b1, 16'h0100, 16'h7777, 16'h00A5, 16'h1234, 8'hCD};
        vecs[9]  = '{1'b0, 16'h0101, 16'h0000, 16'h0000, 16'h1234, 8'hCD};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 8'hCD};
        vecs[11] = '{1'b1, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF, 8'hCD};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 8'hCD};
        vecs[13] = '{1'b0, 16'h0001, 16'h0000, 16'h00CD, 16'hBEEF, 8'hCD};

        rst = 1'b1; portaddr = '0; portval = '0; portget = 1'b0; portset = 1'b0;
        sw = 8'hA5; btn = 4'h0;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        repeat (4) @(negedge mclk);

        check("reset portout", portout, 16'h0000);
        check("reset show_val", show_val, 16'h0000);
        check("reset led_val", {8'h00, led_val}, 16'h0000);
        do_read(16'd3, rd); check("reset button", rd, 16'h0000);
        do_read(16'd5, rd); check("reset status", rd, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, rd);
            check($sformatf("vec%0d portout", i), portout, vecs[i].exp_out);
            check($sformatf("vec%0d show_val", i), show_val, vecs[i].exp_show);
            check($sformatf("vec%0d led_val", i), {8'h00, led_val}, {8'h00, vecs[i].exp_led});
        end

        // same-cycle get and set on DISPLAY
        portaddr = 16'd0; portval = 16'h4321; portget = 1'b1; portset = 1'b1;
        @(negedge mclk);
        portget = 1'b0; portset = 1'b0;
        check("getset old value", portout, 16'hBEEF);
        check("getset new show", show_val, 16'h4321);

        // two-cycle glitch is rejected
        btn[2] = 1'b1;
        repeat (2) @(negedge mclk);
        btn[2] = 1'b0;
        repeat (10) @(negedge mclk);
        do_read(16'd3, rd); check("glitch no flag", rd, 16'h0000);

        // held press sets the sticky flag; read-only writes leave it alone
        btn[2] = 1'b1;
        repeat (10) @(negedge mclk);
        btn[2] = 1'b0;
        repeat (10) @(negedge mclk);
        do_write(16'd5, 16'hFFFF);
        do_write(16'd3, 16'hFFFF);
        do_read(16'd3, rd); check("press flag", rd, 16'h0004);
        do_read(16'd3, rd); check("press cleared", rd, 16'h0000);

        // flag set lands on the same edge as a BUTTON read
        btn[1] = 1'b1;
        repeat (5) @(negedge mclk);
        do_read(16'd3, rd); check("set+clear old", rd, 16'h0000);
        do_read(16'd3, rd); check("set+clear kept", rd, 16'h0002);
        btn[1] = 1'b0;
        repeat (10) @(negedge mclk);

        // timer period 2 from a known prescaler phase
        do_reset();
        do_write(16'd4, 16'd2);
        repeat (8) @(negedge mclk);
        do_read(16'd5, rd); check("timer expired", rd, 16'h0001);
        do_read(16'd4, rd); check("timer count zero", rd, 16'h0000);
        do_read(16'd5, rd); check("expired cleared", rd, 16'h0000);

        // reset during a read with flags pending
        btn[0] = 1'b1;
        repeat (10) @(negedge mclk);
        btn[0] = 1'b0;
        repeat (10) @(negedge mclk);
        do_write(16'd0, 16'h0055);
        check("pre-reset show", show_val, 16'h0055);
        rst = 1'b1; portaddr = 16'd0; portget = 1'b1;
        @(negedge mclk);
        rst = 1'b0; portget = 1'b0;
        check("rst portout", portout, 16'h0000);
        check("rst show_val", show_val, 16'h0000);
        check("rst led_val", {8'h00, led_val}, 16'h0000);
        do_read(16'd3, rd); check("rst button flags", rd, 16'h0000);
        do_read(16'd5, rd); check("rst status flag", rd, 16'h0000);

        // period 0: free-running wrap with no expiry
        do_reset();
        repeat (65535) @(negedge mclk);
        do_read(16'd4, rd); check("wrap count ffff", wrap_portout, 16'hFFFF);
        do_read(16'd4, rd); check("wrap count zero", wrap_portout, 16'h0000);
        do_read(16'd5, rd); check("wrap no expiry", wrap_portout, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
